rat_path_stack: RTL
===================

# rat_path_stack

Direction stack for the rat-in-maze solver, directly downstream of `ratInMaze`. During the search, every committed step is pushed and every backtrack pops the last step, so the stack always holds the current route from start to rat. Once the solver reports `done`, asserting `run` replays the stored route from the start cell onward, one move per cycle, for the movement/display stage.

## Interface
Parameters:
- `DEPTH`, 256: maximum stored steps (16x16 maze).
- `CW`, 9: count width; equals clog2(`DEPTH`)+1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `clear` in 1: synchronous empty; also clears the sticky flags.
- `push` in 1: push `dir_in`.
- `pop` in 1: discard the top entry.
- `dir_in` in 2: direction code (0 up, 1 right, 2 down, 3 left).
- `run` in 1: start replay.
- `top_dir` out 2: top entry; 0 when empty.
- `count` out `CW`: number of stored entries.
- `empty` out 1: `count`==0.
- `full` out 1: `count`==`DEPTH`.
- `overflow` out 1: sticky; a push was attempted while full.
- `underflow` out 1: sticky; a pop was attempted while empty.
- `move` out 1: replay strobe; `move_dir` is valid while high.
- `move_dir` out 2: replayed direction.
- `done` out 1: one-cycle pulse at the end of replay.

## Operation
- Storage is `DEPTH`x2 registers. `count` is the write pointer.
- The FSM has three states: BUILD (reset state), REPLAY, DONE.
- **BUILD state:**
  - push only: `mem[count]`<=`dir_in` and `count`+1. If full, the push is ignored and `overflow` is set.
  - pop only: `count`-1. If empty, the pop is ignored and `underflow` is set.
  - push and pop together while not empty: replace the top entry (`mem[count-1]`<=`dir_in`); `count` is unchanged.
  - push and pop together while empty: treated as push only. `underflow` is not set.
  - `clear`: `count`<=0 and both sticky flags are cleared. `clear` has priority over push and pop.
  - `run`==1: go to REPLAY with read index `ri`<=0. Push and pop in that same cycle are ignored.
- **REPLAY state:**
  - Each cycle with `ri`<`count`: `move`=1, `move_dir`=`mem[ri]`, then `ri`+1.
  - When `ri`==`count`: go to DONE.
  - `push`, `pop`, `run` and `clear` are ignored.
  - Contents and `count` are preserved, so the route can be replayed again.
- **DONE state:** `done`=1 for one cycle, then return to BUILD.
- `run` while empty: BUILD -> REPLAY -> DONE with zero `move` pulses.
- Memory contents are not reset. Only `count`, `ri`, the flags and the FSM state are reset.

## Timing
- Reset values: `count`=0, `empty`=1, `full`=0, `top_dir`=0, `overflow`=0, `underflow`=0, `move`=0, `move_dir`=0, `done`=0, state BUILD.
- Reset has priority over every other input. A reset mid-replay aborts the replay; the next cycle shows reset values.
- Push/pop latency is 1: `count`, `empty`, `full` and `top_dir` reflect an operation in the cycle after the edge that samples it.
- `empty`, `full` and `top_dir` are combinational from `count` and `mem`.
- Replay sequence, with `run` sampled at edge E:
  - `move` is high for cycles E+1 .. E+`count`, presenting `mem[0]`..`mem[count-1]` in order.
  - `done` is high in cycle E+`count`+1.
  - BUILD resumes at edge E+`count`+2.
- `move` and `move_dir` are registered outputs. `move_dir` holds its last value when `move`=0.

## Test plan
- Reset, then push 1,2,3 on consecutive cycles -> `count`=3, `top_dir`=3, `empty`=0.
- Push 0,1,2, then one cycle with push and pop together, `dir_in`=3 -> `count`=3, `top_dir`=3. Then pop -> `count`=2, `top_dir`=1.
- Pop while empty -> `underflow`=1, `count`=0. `clear` -> `underflow`=0.
- With `DEPTH`=4: push 5 times -> `count`=4, `full`=1, `overflow`=1, and the stack holds only the first 4 values.
- Stack 2,2,1,3, `run` pulsed -> `move` high for exactly 4 cycles with `move_dir` 2,2,1,3, then a `done` pulse. A second `run` gives an identical sequence.
- `run` while empty -> no `move` pulses, `done` 2 cycles after the sampling edge. `rst`=0 during a 4-entry replay -> `move`=0 and `count`=0 on the next cycle.

Source files
------------

// File: rtl/rat_path_stack.sv
// rat_path_stack: route stack for the rat-in-maze solver.
// Holds the committed step directions (push on step, pop on
// backtrack) and replays them start-to-rat, one per cycle.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-low
//   clear      in   empty the stack, clear sticky flags
//   push/pop   in   stack operations (both = replace top)
//   dir_in     in   direction 0 up, 1 right, 2 down, 3 left
//   run        in   start replay of the stored route
//   top_dir    out  top entry (0 when empty)
//   count      out  number of stored entries
//   empty/full out  count == 0 / count == DEPTH
//   overflow   out  sticky: push attempted while full
//   underflow  out  sticky: pop attempted while empty
//   move       out  replay strobe, move_dir valid while high
//   move_dir   out  replayed direction (holds when move = 0)
//   done       out  one-cycle pulse at end of replay
module rat_path_stack #(
    parameter int DEPTH = 256,
    parameter int CW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    dir_in,
    input  logic          run,
    output logic [1:0]    top_dir,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow,
    output logic          move,
    output logic [1:0]    move_dir,
    output logic          done
);

    localparam int AW = CW - 1;

    localparam logic [1:0] S_BUILD  = 2'd0;
    localparam logic [1:0] S_REPLAY = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [AW-1:0] C_ONE_A = AW'(1);

    logic [1:0]    r_mem [DEPTH];
    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_ri;
    logic          r_ovf;
    logic          r_udf;
    logic          r_move;
    logic [1:0]    r_move_dir;
    logic          r_done;

    logic          w_empty;
    logic          w_full;
    logic [AW-1:0] w_top_idx;
    logic          w_stack_op;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_idx;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_DEPTH);
    // Low bits of count-1; a full stack wraps to DEPTH-1 correctly.
    assign w_top_idx = r_count[AW-1:0] - C_ONE_A;

    // Stack operations only happen in BUILD, and clear/run win.
    assign w_stack_op = (r_state == S_BUILD) && !clear && !run;

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = r_count[AW-1:0];
        if (w_stack_op && push) begin
            if (pop && !w_empty) begin
                w_wr_en  = 1'b1;
                w_wr_idx = w_top_idx;
            end else if (!w_full) begin
                w_wr_en  = 1'b1;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= dir_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_BUILD;
            r_count    <= '0;
            r_ri       <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_move     <= 1'b0;
            r_move_dir <= 2'd0;
            r_done     <= 1'b0;
        end else begin
            r_move <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_BUILD: begin
                    if (clear) begin
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                        r_udf   <= 1'b0;
                    end
                    if (run) begin
                        r_state <= S_REPLAY;
                        r_ri    <= '0;
                    end
                    if (w_stack_op) begin
                        if (push && pop && !w_empty) begin
                            r_count <= r_count;
                        end else if (push) begin
                            if (w_full) r_ovf <= 1'b1;
                            else        r_count <= r_count + C_ONE;
                        end else if (pop) begin
                            if (w_empty) r_udf <= 1'b1;
                            else         r_count <= r_count - C_ONE;
                        end
                    end
                end
                S_REPLAY: begin
                    if (r_ri < r_count) begin
                        r_move     <= 1'b1;
                        r_move_dir <= r_mem[r_ri[AW-1:0]];
                        r_ri       <= r_ri + C_ONE;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_BUILD;
                end
                default: begin
                    r_state <= S_BUILD;
                end
            endcase
        end
    end

    assign top_dir   = w_empty ? 2'd0 : r_mem[w_top_idx];
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_udf;
    assign move      = r_move;
    assign move_dir  = r_move_dir;
    assign done      = r_done;

endmodule
